// File: rtl/multiplier_arbiter_taint.sv
// Round-robin arbiter that shares one sequential multiplier among NREQ requesters,
// with shadow taint tracking on every control and data output.
module multiplier_arbiter_taint #(
   parameter int WIDTH   = 1024,
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 4200
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [NREQ-1:0]       req_i,
   input  logic [NREQ-1:0]       req_t_i,
   input  logic [NREQ*WIDTH-1:0] op_a_i,
   input  logic [NREQ*WIDTH-1:0] op_a_t_i,
   input  logic [NREQ*WIDTH-1:0] op_b_i,
   input  logic [NREQ*WIDTH-1:0] op_b_t_i,
   input  logic                  state_t_kill_i,
   output logic [NREQ-1:0]       gnt_o,
   output logic [NREQ-1:0]       gnt_t_o,
   output logic [NREQ-1:0]       rsp_valid_o,
   output logic [NREQ-1:0]       rsp_valid_t_o,
   output logic                  rsp_err_o,
   output logic                  rsp_err_t_o,
   output logic [2*WIDTH-1:0]    rsp_prod_o,
   output logic [2*WIDTH-1:0]    rsp_prod_t_o,
   output logic                  mul_start_o,
   output logic                  mul_start_t_o,
   output logic [WIDTH-1:0]      mul_md_o,
   output logic [WIDTH-1:0]      mul_md_t_o,
   output logic [WIDTH-1:0]      mul_mr_o,
   output logic [WIDTH-1:0]      mul_mr_t_o,
   input  logic                  mul_done_i,
   input  logic                  mul_done_t_i,
   input  logic [2*WIDTH-1:0]    mul_prod_i,
   input  logic [2*WIDTH-1:0]    mul_prod_t_i
);

   localparam int IW          = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW          = $clog2(TIMEOUT + 1);
   localparam int STATE_WIDTH = 2;

   typedef enum logic [STATE_WIDTH-1:0] {IDLE, ISSUE, BUSY, RESP} state_e;

   state_e                 state_q, state_d;
   logic [STATE_WIDTH-1:0] state_t_q, state_t_d;
   logic [IW-1:0]          ptr_q, ptr_d;
   logic [IW-1:0]          idx_q, idx_d;
   logic                   idx_t_q, idx_t_d;
   logic [WIDTH-1:0]       a_q, a_d, a_t_q, a_t_d;
   logic [WIDTH-1:0]       b_q, b_d, b_t_q, b_t_d;
   logic [2*WIDTH-1:0]     prod_q, prod_d, prod_t_q, prod_t_d;
   logic                   err_q, err_d;
   logic [CW-1:0]          cnt_q, cnt_d;

   logic                   found;
   logic [IW-1:0]          win;
   logic [NREQ-1:0]        scan_mask;
   logic                   scan_t;
   logic                   ctrl_t;
   logic [NREQ-1:0]        idx_onehot;

   // Round-robin scan starting at ptr; scan_mask marks every requester looked at
   // up to and including the winner, since each of those influenced the decision.
   always_comb begin
      int p;
      p         = 0;
      found     = 1'b0;
      win       = ptr_q;
      scan_mask = '0;
      for (int k = 0; k < NREQ; k++) begin
         p = int'(ptr_q) + k;
         if (p >= NREQ) p = p - NREQ;
         if (!found) begin
            scan_mask[p] = 1'b1;
            if (req_i[p]) begin
               found = 1'b1;
               win   = IW'(p);
            end
         end
      end
      scan_t = |(req_t_i & scan_mask);
   end

   // NOTE: every variable gets its default before the case, so no path can leave one unassigned and infer a latch.
   always_comb begin
      state_d   = state_q;
      state_t_d = state_t_q;
      ptr_d     = ptr_q;
      idx_d     = idx_q;
      idx_t_d   = idx_t_q;
      a_d       = a_q;
      a_t_d     = a_t_q;
      b_d       = b_q;
      b_t_d     = b_t_q;
      prod_d    = prod_q;
      prod_t_d  = prod_t_q;
      err_d     = err_q;
      cnt_d     = cnt_q;
      unique case (state_q)
         IDLE: begin
            state_t_d = state_t_q | {STATE_WIDTH{scan_t}};
            idx_t_d   = idx_t_q | scan_t;
            if (found) begin
               state_d = ISSUE;
               idx_d   = win;
               a_d     = op_a_i[win*WIDTH +: WIDTH];
               a_t_d   = op_a_t_i[win*WIDTH +: WIDTH];
               b_d     = op_b_i[win*WIDTH +: WIDTH];
               b_t_d   = op_b_t_i[win*WIDTH +: WIDTH];
            end
         end
         ISSUE: begin
            cnt_d   = '0;
            state_d = BUSY;
         end
         BUSY: begin
            state_t_d = state_t_q | {STATE_WIDTH{mul_done_t_i}};
            idx_t_d   = idx_t_q | mul_done_t_i;
            cnt_d     = cnt_q + CW'(1);
            if (mul_done_i) begin
               prod_d   = mul_prod_i;
               prod_t_d = mul_prod_t_i;
               err_d    = 1'b0;
               state_d  = RESP;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               prod_d   = '0;
               prod_t_d = '0;
               err_d    = 1'b1;
               state_d  = RESP;
            end
         end
         RESP: begin
            ptr_d   = (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + IW'(1);
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (state_t_kill_i) begin
         state_t_d = '0;
         idx_t_d   = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q   <= IDLE;
         state_t_q <= '0;
         ptr_q     <= '0;
         idx_q     <= '0;
         idx_t_q   <= 1'b0;
         a_q       <= '0;
         a_t_q     <= '0;
         b_q       <= '0;
         b_t_q     <= '0;
         prod_q    <= '0;
         prod_t_q  <= '0;
         err_q     <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         state_t_q <= state_t_d;
         ptr_q     <= ptr_d;
         idx_q     <= idx_d;
         idx_t_q   <= idx_t_d;
         a_q       <= a_d;
         a_t_q     <= a_t_d;
         b_q       <= b_d;
         b_t_q     <= b_t_d;
         prod_q    <= prod_d;
         prod_t_q  <= prod_t_d;
         err_q     <= err_d;
         cnt_q     <= cnt_d;
      end
   end

   assign ctrl_t     = (|state_t_q) | idx_t_q;
   assign idx_onehot = NREQ'(1) << idx_q;

   assign gnt_o         = (state_q != IDLE) ? idx_onehot : '0;
   assign gnt_t_o       = {NREQ{ctrl_t}};
   assign rsp_valid_o   = (state_q == RESP) ? idx_onehot : '0;
   assign rsp_valid_t_o = {NREQ{ctrl_t}};
   assign rsp_err_o     = (state_q == RESP) & err_q;
   assign rsp_err_t_o   = ctrl_t;
   assign rsp_prod_o    = (state_q == RESP) ? prod_q : '0;
   assign rsp_prod_t_o  = prod_t_q | {(2*WIDTH){ctrl_t}};
   assign mul_start_o   = (state_q == ISSUE);
   assign mul_start_t_o = ctrl_t;
   assign mul_md_o      = a_q;
   assign mul_md_t_o    = a_t_q | {WIDTH{idx_t_q}};
   assign mul_mr_o      = b_q;
   assign mul_mr_t_o    = b_t_q | {WIDTH{idx_t_q}};

endmodule
